regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_pkg.sv | 14 +
 rtl/regfile_wr_arbiter_rr_arb2.sv | 34 +++
 rtl/regfile_wr_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   DATA_W_DEF / SEL_W_DEF : default data and register-select widths
//   NUM_REGS               : number of registers cleared at start-up
//   state_t                : top-level FSM encoding (clear sequence / normal run)
package regfile_wr_arbiter_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int SEL_W_DEF  = 3;
  localparam int NUM_REGS   = 2 ** SEL_W_DEF;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst : clock and synchronous active-high reset (pointer -> requester 0)
//   en       : arbitration enable; no grant is issued while low
//   valid    : per-requester request bits
//   grant    : one-hot (or zero) grant, combinational from valid and pointer
// The pointer names the requester that wins a tie. After any grant it moves
// to the requester that lost, and it holds when nothing is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // grant[0] set means requester 0 won, so requester 1 is next in line.
  always_ff @(posedge clk) begin
    if (rst)        ptr <= 1'b0;
    else if (|grant) ptr <= grant[0];
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// After reset it walks every register writing zero (O_init_done low), then
// arbitrates between the ALU writeback (req0) and load unit (req1) with a
// round-robin tie break. An accepted write appears on the register file
// port in the following cycle.
//   I_clk, I_rst             : clock, synchronous active-high reset
//   I_reqN_valid/sel/data    : requester N write request
//   O_reqN_ready             : requester N accepted this cycle
//   O_en, O_we, O_selD, O_dataD : register file write port
//   O_init_done              : clear sequence finished
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_req0_valid,
  input  logic [SEL_W-1:0]  I_req0_sel,
  input  logic [DATA_W-1:0] I_req0_data,
  output logic              O_req0_ready,
  input  logic              I_req1_valid,
  input  logic [SEL_W-1:0]  I_req1_sel,
  input  logic [DATA_W-1:0] I_req1_data,
  output logic              O_req1_ready,
  output logic              O_en,
  output logic              O_we,
  output logic [SEL_W-1:0]  O_selD,
  output logic [DATA_W-1:0] O_dataD,
  output logic              O_init_done
);
  state_t            state;
  logic [SEL_W-1:0]  clrCnt;
  logic              weReg;
  logic [SEL_W-1:0]  selReg;
  logic [DATA_W-1:0] dataReg;
  logic [1:0]        grant;
  logic              inClear;

  assign inClear = (state == S_CLEAR);

  rr_arb2 uArb (
    .clk   (I_clk),
    .rst   (I_rst),
    .en    (!inClear && !I_rst),
    .valid ({I_req1_valid, I_req0_valid}),
    .grant (grant)
  );

  assign O_req0_ready = grant[0];
  assign O_req1_ready = grant[1];

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state   <= S_CLEAR;
      clrCnt  <= '0;
      weReg   <= 1'b0;
      selReg  <= '0;
      dataReg <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          weReg <= 1'b0;
          if (clrCnt == '1) begin
            state   <= S_RUN;
            // Seed the hold registers with the last clear write so the
            // port value does not jump when the clear phase ends.
            selReg  <= clrCnt;
            dataReg <= '0;
          end else begin
            clrCnt <= clrCnt + 1'b1;
          end
        end
        S_RUN: begin
          weReg <= |grant;
          if (grant[0]) begin
            selReg  <= I_req0_sel;
            dataReg <= I_req0_data;
          end else if (grant[1]) begin
            selReg  <= I_req1_sel;
            dataReg <= I_req1_data;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Clear writes are decoded straight from the state/counter so the first
  // zero write lands in the first cycle after reset. Reset gates the
  // enables so nothing pending reaches the register file while it is high.
  assign O_en        = !I_rst;
  assign O_we        = !I_rst && (inClear || weReg);
  assign O_selD      = inClear ? clrCnt : selReg;
  assign O_dataD     = inClear ? '0 : dataReg;
  assign O_init_done = (state == S_RUN);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  localparam int DW = 16;
  localparam int SW = 3;
  localparam int NREG = 8;

  logic          I_clk = 1'b0;
  logic          I_rst;
  logic          I_req0_valid, I_req1_valid;
  logic [SW-1:0] I_req0_sel, I_req1_sel;
  logic [DW-1:0] I_req0_data, I_req1_data;
  logic          O_req0_ready, O_req1_ready;
  logic          O_en, O_we, O_init_done;
  logic [SW-1:0] O_selD;
  logic [DW-1:0] O_dataD;

  regfile_wr_arbiter #(.DATA_W(DW), .SEL_W(SW)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_req0_valid(I_req0_valid), .I_req0_sel(I_req0_sel),
    .I_req0_data(I_req0_data), .O_req0_ready(O_req0_ready),
    .I_req1_valid(I_req1_valid), .I_req1_sel(I_req1_sel),
    .I_req1_data(I_req1_data), .O_req1_ready(O_req1_ready),
    .O_en(O_en), .O_we(O_we), .O_selD(O_selD), .O_dataD(O_dataD),
    .O_init_done(O_init_done)
  );

  always #5 I_clk = ~I_clk;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: where we are in the clear walk, who wins the next tie,
  // and what write (if any) the port should be showing.
  bit mClr  = 1'b1;
  int mIdx  = 0;
  int mPtr  = 0;
  bit mPend = 1'b0;
  int mSel  = 0;
  int mData = 0;

  int writes[$];
  int clrWe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int expGrant();
    if (I_rst || mClr) return -1;
    if (I_req0_valid && I_req1_valid) return mPtr;
    if (I_req0_valid) return 0;
    if (I_req1_valid) return 1;
    return -1;
  endfunction

  task automatic checkCycle();
    int g;
    g = expGrant();
    chk("en", 32'(O_en), 32'(!I_rst));
    chk("init_done", 32'(O_init_done), 32'(!mClr));
    if (I_rst) begin
      chk("we_rst", 32'(O_we), 0);
      chk("rdy_rst", {30'd0, O_req1_ready, O_req0_ready}, 0);
    end else if (mClr) begin
      chk("we_clr", 32'(O_we), 1);
      chk("sel_clr", 32'(O_selD), 32'(mIdx));
      chk("data_clr", 32'(O_dataD), 0);
      chk("rdy_clr", {30'd0, O_req1_ready, O_req0_ready}, 0);
    end else begin
      chk("we_run", 32'(O_we), 32'(mPend));
      chk("sel_run", 32'(O_selD), 32'(mSel));
      chk("data_run", 32'(O_dataD), 32'(mData));
      chk("rdy_run", {30'd0, O_req1_ready, O_req0_ready},
          (g < 0) ? 0 : ((g == 0) ? 1 : 2));
    end
    if (!I_rst && O_we && !O_init_done) clrWe++;
    if (!I_rst && O_we && O_init_done) writes.push_back(int'(O_dataD));
  endtask

  task automatic modelStep();
    int g;
    g = expGrant();
    if (I_rst) begin
      mClr = 1; mIdx = 0; mPtr = 0; mPend = 0; mSel = 0; mData = 0;
    end else if (mClr) begin
      mPend = 0;
      if (mIdx == NREG - 1) begin
        mClr = 0; mSel = NREG - 1; mData = 0;
      end else mIdx++;
    end else begin
      mPend = (g >= 0);
      if (g == 0) begin mSel = int'(I_req0_sel); mData = int'(I_req0_data); end
      if (g == 1) begin mSel = int'(I_req1_sel); mData = int'(I_req1_data); end
      if (g >= 0) mPtr = 1 - g;
    end
  endtask

  task automatic tick();
    @(negedge I_clk);
    checkCycle();
    modelStep();
    @(posedge I_clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit v0, input int s0, input int d0,
                       input bit v1, input int s1, input int d1);
    I_rst = r;
    I_req0_valid = v0; I_req0_sel = SW'(s0); I_req0_data = DW'(d0);
    I_req1_valid = v1; I_req1_sel = SW'(s1); I_req1_data = DW'(d1);
  endtask

  task automatic resetAndClear();
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    clrWe = 0;
    repeat (10) tick();
    chk("clear_len", 32'(clrWe), 8);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge I_clk);
    #1;
    repeat (2) tick();

    // Release reset: 8 zero writes, then idle run.
    drive(0, 0, 0, 0, 0, 0, 0);
    clrWe = 0;
    repeat (10) tick();
    chk("clear_len", 32'(clrWe), 8);

    // Single requester write.
    writes.delete();
    drive(0, 1, 2, 'h2222, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("single_cnt", 32'(writes.size()), 1);
    if (writes.size() > 0) chk("single_data", 32'(writes[0]), 'h2222);

    // Sustained contention from a fresh pointer.
    resetAndClear();
    writes.delete();
    drive(0, 1, 4, 'h4444, 1, 5, 'h5555);
    repeat (4) tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    chk("b2b_cnt", 32'(writes.size()), 4);
    if (writes.size() == 4) begin
      chk("b2b_0", 32'(writes[0]), 'h4444);
      chk("b2b_1", 32'(writes[1]), 'h5555);
      chk("b2b_2", 32'(writes[2]), 'h4444);
      chk("b2b_3", 32'(writes[3]), 'h5555);
    end

    // Same destination: grant order decides which data lands last.
    resetAndClear();
    writes.delete();
    drive(0, 1, 0, 'hFFFF, 1, 0, 'hFEED);
    tick();
    drive(0, 0, 0, 0, 1, 0, 'hFEED);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("same_cnt", 32'(writes.size()), 2);
    if (writes.size() == 2) begin
      chk("same_0", 32'(writes[0]), 'hFFFF);
      chk("same_1", 32'(writes[1]), 'hFEED);
    end

    // Reset pulse while a write is pending.
    drive(0, 1, 3, 'h3333, 0, 0, 0);
    tick();
    drive(1, 1, 3, 'h3333, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    clrWe = 0;
    repeat (10) tick();
    chk("rst_pulse_clear", 32'(clrWe), 8);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom,
            $urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
